if_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipelined processor. Holds the program counter and drives the word-indexed address of the combinational instruction memory. Resolves unconditional `j` locally, accepts redirects and stalls from later stages, and registers the fetched word into the IF/ID pipeline register consumed by decode.

---
 rtl/if_stage_if.sv | 23 ++
 rtl/if_stage.sv | 54 +++++
 tb/tb_if_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bundle: control inputs, instruction memory port, IF/ID outputs
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus1;
    logic [31:0] fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_data,
        output imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_data,
        input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch: PC, local j resolution, redirect/stall, IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    if_stage_if.master  bus
);
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus1;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus1;
    logic        w_is_jump;
    logic [31:0] w_next_pc;

    assign w_pc_plus1 = r_pc + 32'd1;
    assign w_is_jump  = (bus.imem_data[31:26] == 6'b000010);
    // Jump target keeps the upper bits of the successor word index, as in a region-relative j.
    assign w_next_pc  = w_is_jump ? {w_pc_plus1[31:26], bus.imem_data[25:0]} : w_pc_plus1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_WORD;
            r_id_pc       <= 32'd0;
            r_id_pc_plus1 <= 32'd0;
            r_fetch_count <= 32'd0;
        end else if (bus.redirect_valid) begin
            r_pc       <= bus.redirect_pc;
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_WORD;
        end else if (!bus.stall) begin
            r_pc          <= w_next_pc;
            r_id_valid    <= 1'b1;
            r_id_instr    <= bus.imem_data;
            r_id_pc       <= r_pc;
            r_id_pc_plus1 <= w_pc_plus1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.id_valid    = r_id_valid;
    assign bus.id_instr    = r_id_instr;
    assign bus.id_pc       = r_id_pc;
    assign bus.id_pc_plus1 = r_id_pc_plus1;
    assign bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed-vector bench for if_stage with a combinational instruction RAM
module tb_if_stage;
    logic clk;
    logic reset_n;
    logic [31:0] ram [0:63];
    int n_vec;
    int n_err;

    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Words outside the modelled RAM read as a non-jump addi.
    assign bus.imem_data = (bus.imem_addr < 32'd64) ? ram[bus.imem_addr[5:0]] : 32'h2000_00FF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] pc1, input logic [31:0] fc);
        chk({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, v});
        chk({tag, ".instr"}, bus.id_instr, instr);
        chk({tag, ".pc"}, bus.id_pc, pc);
        chk({tag, ".pc1"}, bus.id_pc_plus1, pc1);
        chk({tag, ".fc"}, bus.fetch_count, fc);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h2000_0000 + i;
        ram[0] = 32'h2001_0001;
        ram[1] = 32'h2002_0002;
        ram[2] = 32'h0800_0001;

        reset_n            = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.addr", bus.imem_addr, 32'd0);
        chk_id("rst", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        reset_n = 1'b1;
        tick();
        chk_id("e1", 1'b1, 32'h2001_0001, 32'd0, 32'd1, 32'd1);
        chk("e1.addr", bus.imem_addr, 32'd1);
        tick();
        chk_id("e2", 1'b1, 32'h2002_0002, 32'd1, 32'd2, 32'd2);
        chk("e2.addr", bus.imem_addr, 32'd2);
        tick();
        chk_id("jmp", 1'b1, 32'h0800_0001, 32'd2, 32'd3, 32'd3);
        chk("jmp.addr", bus.imem_addr, 32'd1);
        tick();
        chk("seq4.pc", bus.id_pc, 32'd1);
        chk("seq4.addr", bus.imem_addr, 32'd2);
        tick();
        chk("seq5.pc", bus.id_pc, 32'd2);
        chk("seq5.addr", bus.imem_addr, 32'd1);
        tick();
        chk("e6.addr", bus.imem_addr, 32'd2);

        // Redirect wins over both stall and the jump word sitting at pc=2.
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd40;
        tick();
        chk("rdr.addr", bus.imem_addr, 32'd40);
        chk_id("rdr", 1'b0, 32'd0, 32'd1, 32'd2, 32'd6);
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        chk_id("rdr2", 1'b1, 32'h2000_0028, 32'd40, 32'd41, 32'd7);
        chk("rdr2.addr", bus.imem_addr, 32'd41);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd4;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk_id("pre", 1'b1, 32'h2000_0004, 32'd4, 32'd5, 32'd8);
        chk("pre.addr", bus.imem_addr, 32'd5);
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stl.addr", bus.imem_addr, 32'd5);
            chk_id("stl", 1'b1, 32'h2000_0004, 32'd4, 32'd5, 32'd8);
        end
        bus.stall = 1'b0;
        tick();
        chk_id("rel", 1'b1, 32'h2000_0005, 32'd5, 32'd6, 32'd9);
        chk("rel.addr", bus.imem_addr, 32'd6);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        tick();
        chk("wrp.addr0", bus.imem_addr, 32'hFFFF_FFFF);
        bus.redirect_valid = 1'b0;
        tick();
        chk_id("wrp", 1'b1, 32'h2000_00FF, 32'hFFFF_FFFF, 32'd0, 32'd10);
        chk("wrp.addr", bus.imem_addr, 32'd0);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd29;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("ar.pre", bus.imem_addr, 32'd30);
        // Drop reset between edges, with stall pending, and sample before the next posedge.
        #2;
        bus.stall = 1'b1;
        reset_n   = 1'b0;
        #1;
        chk("ar.addr", bus.imem_addr, 32'd0);
        chk_id("ar", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("ar2.addr", bus.imem_addr, 32'd0);
        bus.stall = 1'b0;
        reset_n   = 1'b1;
        tick();
        chk_id("ar3", 1'b1, 32'h2001_0001, 32'd0, 32'd1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
